// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED PWM driver and its timing blocks.
package led_pkg;

    localparam int PWM_BITS         = 8;
    localparam int DEFAULT_PRESCALE = 520;

    // Minimum width of 1 so single-entry counters and indices stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides the oscillator clock into a one-cycle phase-step strobe.
module pwm_prescaler
    import led_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pwm_driver.sv
// Per-channel 8-bit PWM for the LED bank; duty writes are shadowed and
// swapped into the active set only at period boundaries.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int CHANNELS   = 8,
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [3:0]          wr_channel,
    input  logic [PWM_BITS-1:0] wr_duty,
    output logic                frame_tick,
    output logic [CHANNELS-1:0] leds
);

    localparam int CIW = clog2(CHANNELS);
    localparam logic [CHANNELS-1:0] DARK = {CHANNELS{ACTIVE_LOW}};

    logic                tick;
    logic                boundary;
    logic                wr_fire;
    logic                wr_hit;
    logic [CIW-1:0]      wr_idx;
    logic [PWM_BITS-1:0] phase_q, phase_d;
    logic                ready_q, ready_d;
    logic                frame_q, frame_d;
    logic [CHANNELS-1:0] leds_q, leds_d;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        boundary = tick && (phase_q == '1);
        wr_ready = ready_q && !boundary;
        wr_fire  = wr_valid && wr_ready;
        // Out-of-range channels still handshake; their data is dropped here.
        wr_hit   = wr_fire && (int'(wr_channel) < CHANNELS);
        wr_idx   = wr_channel[CIW-1:0];
        ready_d  = 1'b1;
        frame_d  = boundary;
        phase_d  = tick ? phase_q + PWM_BITS'(1) : phase_q;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PWM_BITS-1:0] shadow_q, shadow_d;
        logic [PWM_BITS-1:0] active_q, active_d;

        always_comb begin
            shadow_d = shadow_q;
            if (wr_hit && (wr_idx == CIW'(i))) shadow_d = wr_duty;
            active_d = boundary ? shadow_q : active_q;
        end

        assign leds_d[i] = (phase_q < active_q) ^ ACTIVE_LOW;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            ready_q <= 1'b0;
            frame_q <= 1'b0;
            leds_q  <= DARK;
        end else begin
            phase_q <= phase_d;
            ready_q <= ready_d;
            frame_q <= frame_d;
            leds_q  <= leds_d;
        end
    end

    assign frame_tick = frame_q;
    assign leds       = leds_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench: expected per-period low counts are queued at write time.
module tb_led_pwm_driver;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_valid, a_ready, a_ft;
    logic [3:0] a_ch;
    logic [7:0] a_duty, a_leds;
    logic       b_valid, b_ready, b_ft;
    logic [3:0] b_ch;
    logic [7:0] b_duty, b_leds;

    typedef struct {
        int ch;
        int exp;
    } exp_t;

    exp_t sb[$];
    int   lows[8];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clock = ~clock;

    led_pwm_driver #(.CHANNELS(8), .PRESCALE(2), .ACTIVE_LOW(1'b1)) dut_a (
        .clock(clock), .reset(reset),
        .wr_valid(a_valid), .wr_ready(a_ready),
        .wr_channel(a_ch), .wr_duty(a_duty),
        .frame_tick(a_ft), .leds(a_leds)
    );

    led_pwm_driver #(.CHANNELS(8), .PRESCALE(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clock(clock), .reset(reset),
        .wr_valid(b_valid), .wr_ready(b_ready),
        .wr_channel(b_ch), .wr_duty(b_duty),
        .frame_tick(b_ft), .leds(b_leds)
    );

    task automatic push(input int ch, input int e);
        exp_t x;
        x.ch  = ch;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_sb(input string tag);
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            n_total++;
            if (lows[x.ch] !== x.exp)
                $display("FAIL %s ch%0d low_cycles=%0d expected=%0d",
                         tag, x.ch, lows[x.ch], x.exp);
            else n_pass++;
        end
    endtask

    task automatic sample(input bit sel);
        for (int c = 0; c < 8; c++)
            if ((sel ? b_leds[c] : a_leds[c]) === 1'b0) lows[c]++;
    endtask

    task automatic clear_lows();
        for (int c = 0; c < 8; c++) lows[c] = 0;
    endtask

    task automatic measure(input bit sel, input int len);
        clear_lows();
        repeat (len) begin
            @(negedge clock);
            sample(sel);
        end
    endtask

    task automatic wait_frame(input bit sel, input string tag, output int n);
        n = -1;
        clear_lows();
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clock);
            sample(sel);
            if ((sel ? b_ft : a_ft) === 1'b1) begin
                n = i;
                break;
            end
        end
        n_total++;
        if (n < 0) $display("FAIL %s frame_tick timeout", tag);
        else n_pass++;
    endtask

    task automatic do_write(input bit sel, input int ch, input int duty,
                            input string tag);
        bit done;
        done = 1'b0;
        if (!sel) begin
            a_valid = 1'b1; a_ch = ch[3:0]; a_duty = duty[7:0];
        end else begin
            b_valid = 1'b1; b_ch = ch[3:0]; b_duty = duty[7:0];
        end
        for (int i = 0; i < 8; i++) begin
            #1;
            if ((sel ? b_ready : a_ready) === 1'b1) begin
                @(posedge clock);
                done = 1'b1;
                break;
            end
            @(negedge clock);
        end
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clock);
        n_total++;
        if (!done) $display("FAIL %s handshake done=0 expected=1", tag);
        else n_pass++;
    endtask

    task automatic test_reset();
        int n;
        n_total++;
        if (a_leds !== 8'hFF) $display("FAIL rst_leds got=%h exp=ff", a_leds);
        else n_pass++;
        n_total++;
        if (a_ft !== 1'b0 || a_ready !== 1'b0)
            $display("FAIL rst_ft_rdy got=%b%b exp=00", a_ft, a_ready);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (a_ready !== 1'b0) $display("FAIL rdy_pre_edge got=%b exp=0", a_ready);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (a_ready !== 1'b1) $display("FAIL rdy_post_edge got=%b exp=1", a_ready);
        else n_pass++;
        wait_frame(0, "first_frame", n);
        n_total++;
        if (n + 1 !== 512) $display("FAIL first_frame got=%0d exp=512", n + 1);
        else n_pass++;
        do_write(0, 5, 255, "wr_ch5");
        wait_frame(0, "frame_ch5", n);
        repeat (20) @(negedge clock);
        n_total++;
        if (a_leds[5] !== 1'b0) $display("FAIL ch5_lit got=%b exp=0", a_leds[5]);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (a_leds !== 8'hFF) $display("FAIL async_leds got=%h exp=ff", a_leds);
        else n_pass++;
        n_total++;
        if (a_ft !== 1'b0 || a_ready !== 1'b0)
            $display("FAIL async_ft_rdy got=%b%b exp=00", a_ft, a_ready);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_total++;
        if (a_ready !== 1'b1) $display("FAIL rdy_rerelease got=%b exp=1", a_ready);
        else n_pass++;
        wait_frame(0, "frame_rerelease", n);
        n_total++;
        if (n + 1 !== 512) $display("FAIL frame_rerelease got=%0d exp=512", n + 1);
        else n_pass++;
    endtask

    task automatic test_duty_apply();
        int n;
        do_write(0, 0, 64, "wr_ch0");
        do_write(0, 7, 255, "wr_ch7");
        for (int c = 0; c < 8; c++) push(c, 0);
        wait_frame(0, "apply_frame", n);
        check_sb("hold_until_boundary");
        push(0, 128);
        push(7, 510);
        for (int c = 1; c < 7; c++) push(c, 0);
        measure(0, 512);
        check_sb("duty_apply");
    endtask

    task automatic test_boundary_collision();
        int n;
        wait_frame(0, "coll_sync", n);
        repeat (511) @(negedge clock);
        a_valid = 1'b1;
        a_ch    = 4'd3;
        a_duty  = 8'd128;
        #1;
        n_total++;
        if (a_ready !== 1'b0) $display("FAIL coll_ready got=%b exp=0", a_ready);
        else n_pass++;
        @(negedge clock);
        n_total++;
        if (a_ready !== 1'b1 || a_ft !== 1'b1)
            $display("FAIL coll_next rdy_ft=%b%b exp=11", a_ready, a_ft);
        else n_pass++;
        @(posedge clock);
        #1 a_valid = 1'b0;
        @(negedge clock);
        push(3, 0);
        wait_frame(0, "coll_frame", n);
        check_sb("coll_still_dark");
        push(3, 256);
        push(0, 128);
        push(7, 510);
        measure(0, 512);
        check_sb("coll_apply");
    endtask

    task automatic test_last_write();
        int n;
        do_write(0, 2, 10, "wr_ch2_a");
        do_write(0, 2, 200, "wr_ch2_b");
        do_write(0, 12, 99, "wr_ch12");
        wait_frame(0, "lw_frame", n);
        push(2, 400);
        push(3, 256);
        push(0, 128);
        push(7, 510);
        push(1, 0);
        push(4, 0);
        push(5, 0);
        push(6, 0);
        measure(0, 512);
        check_sb("last_write");
    endtask

    task automatic test_duty_zero();
        int n;
        int bad;
        int got;
        int pos[$];
        bad = 0;
        for (int c = 0; c < 8; c++) do_write(0, c, 0, "wr_zero");
        wait_frame(0, "zero_frame", n);
        for (int i = 1; i <= 1536; i++) begin
            @(negedge clock);
            if (a_ft === 1'b1) pos.push_back(i);
            if (a_leds !== 8'hFF) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL zero_dark bad_cycles=%0d exp=0", bad);
        else n_pass++;
        n_total++;
        if (pos.size() !== 3) $display("FAIL ft_count got=%0d exp=3", pos.size());
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            got = (k < pos.size()) ? pos[k] : -1;
            n_total++;
            if (got !== 512 * (k + 1))
                $display("FAIL ft_pos%0d got=%0d exp=%0d", k, got, 512 * (k + 1));
            else n_pass++;
        end
    endtask

    task automatic test_prescale1();
        int n;
        do_write(1, 1, 1, "p1_wr");
        wait_frame(1, "p1_frame", n);
        push(1, 1);
        push(0, 0);
        measure(1, 256);
        check_sb("p1_period_a");
        push(1, 1);
        measure(1, 256);
        check_sb("p1_period_b");
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_ch = '0; a_duty = '0;
        b_valid = 1'b0; b_ch = '0; b_duty = '0;
        repeat (3) @(negedge clock);
        test_reset();
        test_duty_apply();
        test_boundary_collision();
        test_last_write();
        test_duty_zero();
        test_prescale1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Drives the board LED bank with per-channel 8-bit brightness instead of raw on/off bits.
- Sits downstream of any pattern source, such as a free-running counter, sequencer or bus agent. That source writes duty values through a valid/ready port; this block produces the physical LED pins.
- Duty updates are double-buffered and applied only at PWM period boundaries, so brightness changes are glitch-free.
- Runs from the on-chip oscillator clock (133 MHz nominal).

Parameters:
- CHANNELS, 8, number of LED outputs (1..16).
- PRESCALE, 520, oscillator cycles per PWM phase step (>=1); 133 MHz/520/256 gives a period of about 1 kHz.
- ACTIVE_LOW, 1, when 1 the LED pins are driven low to light; when 0, high to light.

Ports:
- clock  input  1  oscillator clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  block can accept a write this cycle.
- wr_channel  input  4  target channel index.
- wr_duty  input  8  new duty value, 0..255.
- frame_tick  output  1  one-cycle pulse after each period boundary.
- leds  output  CHANNELS  registered LED pins.

Behaviour:
- Reset (async, active-high):
  - prescaler=0, phase=0, all shadow and active duties=0, frame_tick=0, wr_ready=0.
  - leds = all LEDs dark: all ones if ACTIVE_LOW, else all zeros.
  - wr_ready rises on the first clock edge after reset deasserts.
- Prescaler:
  - counts 0..PRESCALE-1, then wraps to 0.
  - tick is asserted combinationally when prescaler==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
- Phase:
  - 8-bit counter, increments on tick and wraps 255->0.
  - boundary = tick && phase==255.
- On the boundary edge:
  - phase<=0.
  - active[i]<=shadow[i] for every channel, atomically.
  - frame_tick<=1 for exactly one cycle.
- Write handshake:
  - a transfer happens on any edge with wr_valid && wr_ready; then shadow[wr_channel]<=wr_duty.
  - wr_ready=0 in the boundary cycle (combinationally: tick && phase==255); otherwise 1 outside reset.
  - a write held valid across the boundary is accepted on the next cycle and takes effect at the following boundary.
  - wr_channel>=CHANNELS: handshake completes and the data is discarded.
  - repeated writes to one channel within a period: the last one wins.
- Output:
  - on[i] = (phase < active[i]).
  - leds[i] <= on[i] XOR ACTIVE_LOW, registered, so there is 1 cycle of latency after phase.
  - duty 0 gives always dark.
  - duty d gives lit for d*PRESCALE cycles per 256*PRESCALE-cycle period.
  - duty 255 gives 255/256 lit; a fully-on level does not exist by design.
- Timing from a write:
  - new duty first visible on leds 1 cycle after the next boundary.
  - worst case is one full period plus 2 cycles.
- Reset mid-period: all state returns to reset values immediately; pending shadow writes are lost.

Decomposition:
- Package led_pkg holds:
  - PWM_BITS=8.
  - DEFAULT_PRESCALE=520.
  - channel-index width function clog2(CHANNELS).
- Sub-module pwm_prescaler (parameter PRESCALE, ports clock, reset, tick) generates the phase-step strobe. It is reusable by other timing blocks.
- Shadow/active registers and the compare logic stay in led_pwm_driver as a generate loop.

Test Plan (PRESCALE=2, CHANNELS=8, ACTIVE_LOW=1; period=512 cycles):
- Reset: assert reset mid-run.
  - Required response: leds=8'hFF, frame_tick=0, wr_ready=0 immediately and asynchronously.
  - After release, wr_ready=1 after one edge; first frame_tick 512 cycles after release.
- Duty apply: write ch0=64, ch7=255 in period N.
  - Required response: leds unchanged until the boundary.
  - In period N+1, leds[0] is low for exactly 128 of 512 cycles.
  - leds[7] is low for 510 of 512 cycles; channels 1-6 stay high.
- Boundary collision: hold wr_valid with ch3=128 across the boundary cycle.
  - Required response: wr_ready=0 for that single cycle; the transfer completes 1 cycle later.
  - ch3 is still dark in the next period and 256/512 low in the period after.
- Last-write-wins / out-of-range: write ch2=10, then ch2=200, then ch12=99 in one period.
  - Required response: ch2 lit 400 cycles next period.
  - The ch12 handshake completes; no LED changes.
- Duty 0 and frame_tick: all channels 0 for 3 periods.
  - Required response: leds=8'hFF throughout.
  - frame_tick is exactly 3 single-cycle pulses spaced 512 cycles apart.
- PRESCALE=1 build: ch1=1.
  - Required response: leds[1] low for exactly 1 of every 256 cycles.
